// File: rtl/data_mem_ctrl_if.sv
// Purpose: request/response bundle between the MEM-stage load/store logic and data_mem_ctrl.
// Latency: none (wires only).
// Backpressure: valid/ready on the request side, valid/ready on the response side.
// Ports: master = pipeline side (drives req_*, clr, rsp_ready); slave = controller side.
interface data_mem_ctrl_if #(
    parameter int ADDR_BITS = 10
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [ADDR_BITS+1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 clr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, clr, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Purpose: MEM-stage data memory controller: byte/half/word loads and stores, alignment check, clear sweep.
// Latency: rsp_valid rises LATENCY+1 edges after acceptance; clear takes 2^ADDR_BITS cycles.
// Backpressure: one request in flight; req_ready low until the cycle after the response handshake.
// Ports: clk, rst_n (async active-low), bus (slave modport of data_mem_ctrl_if).
module data_mem_ctrl #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1
) (
    input logic             clk,
    input logic             rst_n,
    data_mem_ctrl_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_BITS;
    // WAIT lasts LATENCY cycles: the counter is loaded with LATENCY-1 and leaves at 0.
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP,
        S_CLEAR
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   clr_pend_q, clr_pend_d;
    logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_d;
    logic                   accept;

    // Latched request
    logic                   r_we;
    logic                   r_uns;
    logic [1:0]             r_size;
    logic [ADDR_BITS+1:0]   r_addr;
    logic [31:0]            r_wdata;

    logic [31:0]            rsp_rdata_q;
    logic                   rsp_err_q;

    // Data array; deliberately not reset, only the clear sweep zeroes it.
    logic [31:0]            mem [DEPTH];

    // Access datapath
    logic [1:0]             lane;
    logic [ADDR_BITS-1:0]   word_idx;
    logic [4:0]             shamt;
    logic [31:0]            rd_word;
    logic [31:0]            rd_shifted;
    logic [31:0]            ld_val;
    logic [31:0]            wd_shifted;
    logic [3:0]             lane_en;
    logic [31:0]            merged;
    logic                   acc_err;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [31:0]            mem_wdata;

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_pend_d = clr_pend_q;
        clr_addr_d = clr_addr_q;
        accept     = 1'b0;

        // A clear seen while busy is remembered and served on the next IDLE cycle.
        if (bus.clr && (state_q != S_IDLE)) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                clr_addr_d = '0;
                if (bus.clr || clr_pend_q) begin
                    state_d    = S_CLEAR;
                    clr_pend_d = 1'b0;
                end else if (bus.req_valid) begin
                    accept = 1'b1;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- Access datapath ----------------
    always_comb begin
        lane       = r_addr[1:0];
        word_idx   = r_addr[ADDR_BITS+1:2];
        shamt      = {lane, 3'b000};
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> shamt;
        wd_shifted = r_wdata << shamt;

        case (r_size)
            2'd0:    acc_err = 1'b0;
            2'd1:    acc_err = r_addr[0];
            2'd2:    acc_err = (r_addr[1:0] != 2'd0);
            default: acc_err = 1'b1;
        endcase

        case (r_size)
            2'd0:    ld_val = {{24{~r_uns & rd_shifted[7]}},  rd_shifted[7:0]};
            2'd1:    ld_val = {{16{~r_uns & rd_shifted[15]}}, rd_shifted[15:0]};
            default: ld_val = rd_shifted;
        endcase

        case (r_size)
            2'd0:    lane_en = 4'b0001 << lane;
            2'd1:    lane_en = 4'b0011 << lane;
            2'd2:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase

        // Read-modify-write keeps the lanes that the store does not address.
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = wd_shifted[8*i +: 8];
            end
        end
    end

    // Single write port shared by the clear sweep and stores.
    always_comb begin
        mem_we    = (state_q == S_CLEAR) || ((state_q == S_ACCESS) && r_we && !acc_err);
        mem_waddr = (state_q == S_CLEAR) ? clr_addr_q : word_idx;
        mem_wdata = (state_q == S_CLEAR) ? 32'd0 : merged;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            clr_pend_q  <= 1'b0;
            clr_addr_q  <= '0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            clr_addr_q <= clr_addr_d;
            if (accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            // Response is captured once and then held through RESP backpressure.
            if (state_q == S_ACCESS) begin
                rsp_rdata_q <= (r_we || acc_err) ? 32'd0 : ld_val;
                rsp_err_q   <= acc_err;
            end
        end
    end

    // ---------------- Outputs ----------------
    // rst_n gates req_ready so every output reads 0 while reset is held.
    assign bus.req_ready = rst_n && (state_q == S_IDLE) && !clr_pend_q && !bus.clr;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
